// File: rtl/ycc_pkg.sv
// Shared constants, FSM state encoding and output beat layout for the
// 4:4:4 to 4:2:2 chroma subsampler.
package ycc_pkg;

  localparam logic [7:0] Y_BLACK = 8'h10;
  localparam logic [7:0] C_ZERO  = 8'h80;

  typedef enum logic [1:0] {
    EVEN  = 2'd0,
    ODD   = 2'd1,
    SEND0 = 2'd2,
    SEND1 = 2'd3
  } ycc_state_e;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] c;
    logic       csel;
    logic       sol;
    logic       eol;
  } ycc_beat_t;

endpackage

// File: rtl/ycc_avg2.sv
// Combinational two-input 8-bit averager; ROUND=1 rounds half up, ROUND=0 truncates.
module ycc_avg2 #(
  parameter int ROUND = 1
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] avg_o
);

  logic [8:0] sum;

  // Nine bits hold 255+255+1, so the sum never wraps.
  assign sum   = {1'b0, a_i} + {1'b0, b_i} + ((ROUND != 0) ? 9'd1 : 9'd0);
  assign avg_o = 8'(sum >> 1);

endmodule

// File: rtl/ycc444_to_422.sv
// Pairs 4:4:4 pixels and emits two 4:2:2 beats per pair (Y0/Cb then Y1/Cr),
// with odd-length line and early start-of-line handling.
module ycc444_to_422
  import ycc_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_y,
  input  logic [7:0] in_cb,
  input  logic [7:0] in_cr,
  input  logic       in_sol,
  input  logic       in_eol,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic [7:0] out_c,
  output logic       out_csel,
  output logic       out_sol,
  output logic       out_eol,
  output logic       err
);

  // Handshake: a pixel moves when in_valid & in_ready at a rising edge; a beat
  // moves when out_valid & out_ready. Beats hold steady while out_ready is low.

  ycc_state_e state_q;
  ycc_beat_t  out_q;
  ycc_beat_t  beat1_q;
  logic       out_valid_q;
  logic       err_q;

  logic [7:0] y0_q, cb0_q, cr0_q;
  logic       sol0_q;

  logic       pend_v_q;
  logic [7:0] pend_y_q, pend_cb_q, pend_cr_q;
  logic       pend_eol_q;

  logic [7:0] cb_avg, cr_avg;
  logic       in_fire;

  ycc_avg2 #(.ROUND(ROUND)) u_avg_cb (.a_i(cb0_q), .b_i(in_cb), .avg_o(cb_avg));
  ycc_avg2 #(.ROUND(ROUND)) u_avg_cr (.a_i(cr0_q), .b_i(in_cr), .avg_o(cr_avg));

  assign in_ready = (state_q == EVEN) || (state_q == ODD);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EVEN;
      out_q       <= '{Y_BLACK, C_ZERO, 1'b0, 1'b0, 1'b0};
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      pend_v_q    <= 1'b0;
    end else begin
      case (state_q)
        EVEN: begin
          if (in_fire) begin
            if (in_eol) begin
              out_q       <= '{in_y, in_cb, 1'b0, in_sol, 1'b1};
              out_valid_q <= 1'b1;
              state_q     <= SEND1;
            end else begin
              y0_q    <= in_y;
              cb0_q   <= in_cb;
              cr0_q   <= in_cr;
              sol0_q  <= in_sol;
              state_q <= ODD;
            end
          end
        end
        ODD: begin
          if (in_fire) begin
            out_valid_q <= 1'b1;
            if (in_sol) begin
              // New line started mid-pair: flush the held pixel alone and park the new one.
              out_q      <= '{y0_q, cb0_q, 1'b0, sol0_q, 1'b1};
              pend_v_q   <= 1'b1;
              pend_y_q   <= in_y;
              pend_cb_q  <= in_cb;
              pend_cr_q  <= in_cr;
              pend_eol_q <= in_eol;
              err_q      <= 1'b1;
              state_q    <= SEND1;
            end else begin
              out_q   <= '{y0_q, cb_avg, 1'b0, sol0_q, 1'b0};
              beat1_q <= '{in_y, cr_avg, 1'b1, 1'b0, in_eol};
              state_q <= SEND0;
            end
          end
        end
        SEND0: begin
          if (out_ready) begin
            out_q   <= beat1_q;
            state_q <= SEND1;
          end
        end
        SEND1: begin
          if (out_ready) begin
            if (pend_v_q && pend_eol_q) begin
              // Parked pixel is itself a one-pixel line: emit it as a lone Cb beat.
              out_q    <= '{pend_y_q, pend_cb_q, 1'b0, 1'b1, 1'b1};
              pend_v_q <= 1'b0;
            end else begin
              out_valid_q <= 1'b0;
              pend_v_q    <= 1'b0;
              if (pend_v_q) begin
                y0_q    <= pend_y_q;
                cb0_q   <= pend_cb_q;
                cr0_q   <= pend_cr_q;
                sol0_q  <= 1'b1;
                state_q <= ODD;
              end else begin
                state_q <= EVEN;
              end
            end
          end
        end
        default: state_q <= EVEN;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_q.y;
  assign out_c     = out_q.c;
  assign out_csel  = out_q.csel;
  assign out_sol   = out_q.sol;
  assign out_eol   = out_q.eol;
  assign err       = err_q;

endmodule

// File: tb/tb_ycc444_to_422.sv
// Bench for ycc444_to_422: one instance per rounding mode on shared stimulus,
// checked against a pixel-level line model with per-instance expected queues.
module tb_ycc444_to_422;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_y = '0, in_cb = '0, in_cr = '0;
  logic       in_sol = 1'b0, in_eol = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready1, out_valid1, out_csel1, out_sol1, out_eol1, err1;
  logic [7:0] out_y1, out_c1;
  logic       in_ready0, out_valid0, out_csel0, out_sol0, out_eol0, err0;
  logic [7:0] out_y0, out_c0;

  int errors = 0;
  int checks = 0;
  int ready_mode = 1;  // 0 random, 1 always ready, 2 stalled

  logic [18:0] exp1_q[$];
  logic [18:0] exp0_q[$];
  logic        h_v = 1'b0, h_sol = 1'b0, err_exp = 1'b0;
  logic [7:0]  h_y, h_cb, h_cr;
  logic        stall = 1'b0;
  logic [18:0] prev1, prev0;

  ycc444_to_422 #(.ROUND(1)) dut_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_sol(in_sol), .in_eol(in_eol),
    .out_valid(out_valid1), .out_ready(out_ready), .out_y(out_y1), .out_c(out_c1),
    .out_csel(out_csel1), .out_sol(out_sol1), .out_eol(out_eol1), .err(err1)
  );

  ycc444_to_422 #(.ROUND(0)) dut_r0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_sol(in_sol), .in_eol(in_eol),
    .out_valid(out_valid0), .out_ready(out_ready), .out_y(out_y0), .out_c(out_c0),
    .out_csel(out_csel0), .out_sol(out_sol0), .out_eol(out_eol0), .err(err0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [18:0] mk_beat(input logic [7:0] y, input logic [7:0] c,
                                          input logic csel, input logic sol, input logic eol);
    return {y, c, csel, sol, eol};
  endfunction

  function automatic logic [7:0] avg_m(input int a, input int b, input int r);
    int s;
    s = (a + b + r) / 2;
    return s[7:0];
  endfunction

  task automatic push_both(input logic [18:0] b);
    exp1_q.push_back(b);
    exp0_q.push_back(b);
  endtask

  task automatic model_accept(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                              input logic sol, input logic eol);
    if (h_v && sol) begin
      push_both(mk_beat(h_y, h_cb, 1'b0, h_sol, 1'b1));
      h_v     = 1'b0;
      err_exp = 1'b1;
    end
    if (!h_v) begin
      if (eol) push_both(mk_beat(y, cb, 1'b0, sol, 1'b1));
      else begin
        h_v = 1'b1; h_y = y; h_cb = cb; h_cr = cr; h_sol = sol;
      end
    end else begin
      exp1_q.push_back(mk_beat(h_y, avg_m(h_cb, cb, 1), 1'b0, h_sol, 1'b0));
      exp1_q.push_back(mk_beat(y, avg_m(h_cr, cr, 1), 1'b1, 1'b0, eol));
      exp0_q.push_back(mk_beat(h_y, avg_m(h_cb, cb, 0), 1'b0, h_sol, 1'b0));
      exp0_q.push_back(mk_beat(y, avg_m(h_cr, cr, 0), 1'b1, 1'b0, eol));
      h_v = 1'b0;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [18:0] cur1, cur0;
    cur1 = {out_y1, out_c1, out_csel1, out_sol1, out_eol1};
    cur0 = {out_y0, out_c0, out_csel0, out_sol0, out_eol0};
    if (rst) begin
      exp1_q.delete();
      exp0_q.delete();
      h_v = 1'b0;
      err_exp = 1'b0;
      stall = 1'b0;
    end else begin
      check_eq("in_ready_r1", in_ready1, exp1_q.size() == 0);
      check_eq("in_ready_r0", in_ready0, exp0_q.size() == 0);
      check_eq("out_valid_r1", out_valid1, exp1_q.size() != 0);
      check_eq("out_valid_r0", out_valid0, exp0_q.size() != 0);
      check_eq("err_r1", err1, err_exp);
      check_eq("err_r0", err0, err_exp);
      if (stall) begin
        check_eq("stable_r1", cur1, prev1);
        check_eq("stable_r0", cur0, prev0);
      end
      if (out_valid1 && out_ready && exp1_q.size() != 0) begin
        check_eq("beat_r1", cur1, exp1_q[0]);
        void'(exp1_q.pop_front());
      end
      if (out_valid0 && out_ready && exp0_q.size() != 0) begin
        check_eq("beat_r0", cur0, exp0_q[0]);
        void'(exp0_q.pop_front());
      end
      stall = out_valid1 && !out_ready;
      prev1 = cur1;
      prev0 = cur0;
      if (in_valid && in_ready1) model_accept(in_y, in_cb, in_cr, in_sol, in_eol);
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic sol, input logic eol);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_y = y; in_cb = cb; in_cr = cr; in_sol = sol; in_eol = eol;
    @(negedge clk);
    while (!in_ready1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready1) check_eq("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
    in_sol = 1'($urandom_range(0, 1)); in_eol = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp1_q.size() != 0 || exp0_q.size() != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp1_q.size() != 0 || exp0_q.size() != 0) check_eq("drain_timeout", 0, 1);
    idle(2);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid1, 1'b0);
    check_eq("rst_out_y", out_y1, 8'h10);
    check_eq("rst_out_c", out_c1, 8'h80);
    check_eq("rst_out_c_r0", out_c0, 8'h80);
    check_eq("rst_csel_sol_eol", {out_csel1, out_sol1, out_eol1}, 3'b000);
    check_eq("rst_err", err1, 1'b0);
    check_eq("rst_in_ready", in_ready1, 1'b1);
    idle(1);

    // Reference pair in both rounding modes, including first-beat latency.
    ready_mode = 1;
    idle(2);
    send_px(8'd50, 8'd100, 8'd200, 1'b1, 1'b0);
    send_px(8'd60, 8'd101, 8'd203, 1'b0, 1'b1);
    check_eq("pair_latency", out_valid1, 1'b1);
    check_eq("pair_b0_r1", {out_y1, out_c1, out_csel1}, {8'd50, 8'd101, 1'b0});
    check_eq("pair_b0_r0", {out_y0, out_c0, out_csel0}, {8'd50, 8'd100, 1'b0});
    idle(1);
    check_eq("pair_b1_r1", {out_y1, out_c1, out_csel1}, {8'd60, 8'd202, 1'b1});
    check_eq("pair_b1_r0", {out_y0, out_c0, out_csel0}, {8'd60, 8'd201, 1'b1});
    drain();

    // Backpressure during SEND0.
    ready_mode = 2;
    idle(1);
    send_px(8'd11, 8'd22, 8'd33, 1'b1, 1'b0);
    send_px(8'd44, 8'd55, 8'd66, 1'b0, 1'b0);
    idle(5);
    check_eq("bp_in_ready", in_ready1, 1'b0);
    check_eq("bp_hold_beat0", {out_y1, out_csel1}, {8'd11, 1'b0});
    ready_mode = 1;
    drain();

    // Three-pixel line, then a new pair starting in the even phase.
    send_px(8'd1, 8'd10, 8'd20, 1'b1, 1'b0);
    send_px(8'd2, 8'd12, 8'd22, 1'b0, 1'b0);
    send_px(8'd3, 8'd14, 8'd24, 1'b0, 1'b1);
    drain();
    send_px(8'd4, 8'd16, 8'd26, 1'b1, 1'b0);
    send_px(8'd5, 8'd18, 8'd28, 1'b0, 1'b1);
    drain();

    // Start-of-line on the odd pixel, followed by a one-pixel line after another early sol.
    send_px(8'd70, 8'd80, 8'd90, 1'b1, 1'b0);
    send_px(8'd71, 8'd81, 8'd91, 1'b1, 1'b0);
    send_px(8'd72, 8'd82, 8'd92, 1'b0, 1'b1);
    send_px(8'd73, 8'd83, 8'd93, 1'b1, 1'b0);
    send_px(8'd74, 8'd84, 8'd94, 1'b1, 1'b1);
    drain();
    check_eq("err_sticky", err1, 1'b1);

    // Reset while stalled in SEND1.
    ready_mode = 2;
    idle(1);
    send_px(8'd99, 8'd98, 8'd97, 1'b1, 1'b1);
    idle(3);
    do_reset(1);
    @(negedge clk);
    check_eq("mid_rst_out_valid", out_valid1, 1'b0);
    check_eq("mid_rst_out_y", out_y1, 8'h10);
    check_eq("mid_rst_out_c", out_c1, 8'h80);
    check_eq("mid_rst_in_ready", in_ready1, 1'b1);
    check_eq("mid_rst_err", err1, 1'b0);
    idle(1);

    // Randomized lines with random gaps and random downstream readiness.
    ready_mode = 0;
    for (int i = 0; i < 400; i++) begin
      send_px(8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      idle($urandom_range(0, 2));
    end
    ready_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
